// File: rtl/axi_traffic_gen.sv
// AXI4 master traffic generator: write phase of N bursts, then read-back of the same
// addresses against a per-node data pattern; reports error and cycle counts.
module axi_traffic_gen #(
    parameter int NODE_ID = 0,
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [15:0]       num_txn,
    input  logic [7:0]        burst_len,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_cnt,
    output logic [31:0]       cycle_cnt,
    output logic [ID_W-1:0]   awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic              wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [ID_W-1:0]   bid,
    input  logic              bvalid,
    output logic              bready,
    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
    } state_t;

    localparam logic [ID_W-1:0] MY_ID = ID_W'(NODE_ID);
    localparam logic [7:0]      SEED  = {4'(NODE_ID), 4'h0};

    function automatic logic [DATA_W-1:0] pattern(input logic [7:0] k, input logic [7:0] j);
        logic [7:0] p;
        p = (k + j) ^ SEED;
        return DATA_W'(p);
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] a);
        return (a == 32'hFFFF_FFFF) ? a : a + 32'd1;
    endfunction

    state_t              state_q, state_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [15:0]         err_q, err_d;
    logic [31:0]         cyc_q, cyc_d;
    logic [15:0]         k_q, k_d, num_q, num_d;
    logic [7:0]          j_q, j_d, len_q, len_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, base_q, base_d;
    logic                rd_en_q, rd_en_d;

    logic                last_beat, more_txn;
    logic [ADDR_W-1:0]   next_addr;
    logic [1:0]          beat_errs;

    assign last_beat = (j_q == len_q);
    assign more_txn  = ({1'b0, k_q} + 17'd1) < {1'b0, num_q};
    assign next_addr = addr_q + ADDR_W'({1'b0, len_q} + 9'd1);
    // RLAST mismatch in either direction (early or missing) counts once per beat.
    assign beat_errs = 2'(rid != MY_ID) + 2'(rdata != pattern(k_q[7:0], j_q))
                     + 2'(rlast != last_beat);

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cyc_d   = busy_q ? sat_inc32(cyc_q) : cyc_q;
        k_d     = k_q;
        j_d     = j_q;
        addr_d  = addr_q;
        rd_en_d = rd_en_q;
        num_d   = num_q;
        len_d   = len_q;
        base_d  = base_q;
        case (state_q)
            IDLE: if (start) begin
                rd_en_d = rd_en;
                num_d   = num_txn;
                len_d   = burst_len;
                base_d  = base_addr;
                addr_d  = base_addr;
                k_d     = 16'd0;
                j_d     = 8'd0;
                err_d   = 16'd0;
                cyc_d   = 32'd0;
                busy_d  = 1'b1;
                if (num_txn == 16'd0 || (!wr_en && !rd_en)) state_d = DONE;
                else if (wr_en)                              state_d = WR_ADDR;
                else                                         state_d = RD_ADDR;
            end
            WR_ADDR: if (awready) begin
                j_d     = 8'd0;
                state_d = WR_DATA;
            end
            WR_DATA: if (wready) begin
                if (last_beat) state_d = WR_RESP;
                else           j_d     = j_q + 8'd1;
            end
            WR_RESP: if (bvalid) begin
                if (bid != MY_ID) err_d = sat_add16(err_q, 2'd1);
                if (more_txn) begin
                    k_d     = k_q + 16'd1;
                    addr_d  = next_addr;
                    state_d = WR_ADDR;
                end else if (rd_en_q) begin
                    k_d     = 16'd0;
                    addr_d  = base_q;
                    state_d = RD_ADDR;
                end else begin
                    state_d = DONE;
                end
            end
            RD_ADDR: if (arready) begin
                j_d     = 8'd0;
                state_d = RD_DATA;
            end
            // The burst always ends on beat count, so a bad RLAST cannot desynchronise us.
            RD_DATA: if (rvalid) begin
                err_d = sat_add16(err_q, beat_errs);
                if (last_beat) begin
                    if (more_txn) begin
                        k_d     = k_q + 16'd1;
                        addr_d  = next_addr;
                        state_d = RD_ADDR;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    j_d = j_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 16'd0;
            cyc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
        end
    end

    always_ff @(posedge aclk) begin
        k_q     <= k_d;
        j_q     <= j_d;
        addr_q  <= addr_d;
        rd_en_q <= rd_en_d;
        num_q   <= num_d;
        len_q   <= len_d;
        base_q  <= base_d;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err_cnt   = err_q;
    assign cycle_cnt = cyc_q;

    assign awid    = MY_ID;
    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awsize  = 3'b000;
    assign awburst = 2'b01;
    assign awvalid = (state_q == WR_ADDR);
    assign wdata   = pattern(k_q[7:0], j_q);
    assign wstrb   = 1'b1;
    assign wlast   = last_beat;
    assign wvalid  = (state_q == WR_DATA);
    assign bready  = (state_q == WR_RESP);
    assign arid    = MY_ID;
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = 3'b000;
    assign arburst = 2'b01;
    assign arvalid = (state_q == RD_ADDR);
    assign rready  = (state_q == RD_DATA);

endmodule
